// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage: sequences a 9-bit instruction stream out of an
// async-read instruction memory, resolves branches through a 16-entry jump LUT, and stops on halt.
module fetch_unit #(
  parameter int unsigned     PC_W      = 10,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter logic [8:0]      HALT_CODE = 9'h1FF,
  parameter logic [8:0]      NOP_CODE  = 9'h100
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic [8:0]      imem_data,
  output logic [PC_W-1:0] imem_addr,
  output logic [8:0]      instruction,
  output logic [PC_W-1:0] pc,
  input  logic            branch_cond,
  input  logic            branch_uncond,
  input  logic [3:0]      target_sel,
  input  logic            to_jump,
  input  logic            lut_we,
  input  logic [3:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic            running,
  output logic            done,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            stall_q;
  logic            cond_hold_q;
  logic [PC_W-1:0] lut_q [16];

  logic cond_eff;
  logic taken;
  logic is_halt;
  logic advance;

  // to_jump is only valid on the first cycle of a branch; across a stall we replay the held value.
  assign cond_eff = stall_q ? cond_hold_q : to_jump;
  assign taken    = branch_uncond | (branch_cond & cond_eff);
  assign is_halt  = (imem_data == HALT_CODE);
  assign advance  = (state_q == RUN) && !stall && !is_halt;

  // NOTE: sequential state always uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated in.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!stall && is_halt) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running     = (state_q == RUN);
    done        = (state_q == DONE);
    instruction = running ? imem_data : NOP_CODE;
  end

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if ((state_q != RUN) && start) begin
      pc_d  = START_PC;
      cnt_d = '0;
    end else if (advance) begin
      pc_d  = taken ? lut_q[target_sel] : pc_q + PC_W'(1);
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pc_q        <= START_PC;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      cond_hold_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall;
      cond_hold_q <= cond_eff;
    end
  end

  // NOTE: the LUT is a flop array with reset, so a branch taken before any write lands on 0;
  // the combinational read sees the pre-edge entry, giving old-data on a same-cycle write.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector tables, randomized run against a
// behavioural model, and a narrow-PC instance for wrap and counter saturation.
module tb_fetch_unit;

  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] NOP  = 9'h100;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Main instance, PC_W = 10
  logic        reset, start, stall, bc, bu, tj, we;
  logic [3:0]  tsel, waddr;
  logic [9:0]  wdata;
  logic [8:0]  imem_data, instruction;
  logic [9:0]  imem_addr, pc;
  logic        running, done;
  logic [15:0] instr_count;
  logic [8:0]  imem [1024];

  assign imem_data = imem[imem_addr];

  fetch_unit dut (
    .CLK(CLK), .reset(reset), .start(start), .stall(stall),
    .imem_data(imem_data), .imem_addr(imem_addr), .instruction(instruction), .pc(pc),
    .branch_cond(bc), .branch_uncond(bu), .target_sel(tsel), .to_jump(tj),
    .lut_we(we), .lut_waddr(waddr), .lut_wdata(wdata),
    .running(running), .done(done), .instr_count(instr_count)
  );

  // Narrow instance, PC_W = 4, straight-line program with no halt
  logic        reset2, start2;
  logic [3:0]  imem_addr2, pc2;
  logic [8:0]  instr2;
  logic        run2, done2;
  logic [15:0] cnt2;

  fetch_unit #(.PC_W(4)) dut2 (
    .CLK(CLK), .reset(reset2), .start(start2), .stall(1'b0),
    .imem_data({5'b0, imem_addr2}), .imem_addr(imem_addr2), .instruction(instr2), .pc(pc2),
    .branch_cond(1'b0), .branch_uncond(1'b0), .target_sel(4'h0), .to_jump(1'b0),
    .lut_we(1'b0), .lut_waddr(4'h0), .lut_wdata(4'h0),
    .running(run2), .done(done2), .instr_count(cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst, st, sl, bc, bu;
    logic [3:0] ts;
    bit         tj, we;
    logic [3:0] wa;
    logic [9:0] wd;
    logic [9:0] epc;
    bit         erun, edone;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, st, sl, bc_i, bu_i, input logic [3:0] ts,
                              input bit tj_i, we_i, input logic [3:0] wa, input logic [9:0] wd,
                              input logic [9:0] epc, input bit erun, edone,
                              input logic [15:0] ecnt);
    vecs.push_back('{rst, st, sl, bc_i, bu_i, ts, tj_i, we_i, wa, wd, epc, erun, edone, ecnt});
  endfunction

  task automatic clear_inputs();
    reset = 0; start = 0; stall = 0; bc = 0; bu = 0; tsel = 0; tj = 0;
    we = 0; waddr = 0; wdata = 0;
  endtask

  // Each vector: drive at negedge, clock once, compare post-edge state at the next negedge.
  task automatic run_vecs(input string tag);
    logic [8:0] exp_instr;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; stall = vecs[i].sl;
      bc = vecs[i].bc; bu = vecs[i].bu; tsel = vecs[i].ts; tj = vecs[i].tj;
      we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
      @(posedge CLK);
      @(negedge CLK);
      exp_instr = vecs[i].erun ? imem[vecs[i].epc] : NOP;
      check($sformatf("%s[%0d] pc", tag, i), 32'(pc), 32'(vecs[i].epc));
      check($sformatf("%s[%0d] running", tag, i), 32'(running), 32'(vecs[i].erun));
      check($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(vecs[i].edone));
      check($sformatf("%s[%0d] count", tag, i), 32'(instr_count), 32'(vecs[i].ecnt));
      check($sformatf("%s[%0d] instr", tag, i), 32'(instruction), 32'(exp_instr));
    end
    vecs.delete();
    clear_inputs();
  endtask

  // Behavioural model for the randomized run
  bit m_run, m_done;
  int m_pc, m_cnt;
  int m_lut [16];
  bit hist_stall[$];
  bit hist_tj[$];

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
    hist_stall.delete();
    hist_tj.delete();
  endtask

  // The compare flag in force is the to_jump seen on the first cycle of the current stall run
  // (or this cycle if the previous one was not stalled).
  function automatic bit model_cond();
    for (int s = hist_tj.size() - 1; s >= 0; s--)
      if (s == 0 || !hist_stall[s-1]) return hist_tj[s];
    return 1'b0;
  endfunction

  int steps;
  bit cond, taken;

  initial begin
    clear_inputs();
    reset2 = 1; start2 = 0;
    for (int a = 0; a < 1024; a++) imem[a] = 9'(a & 8'hFF);
    imem[10'h030] = HALT;
    imem[0] = 9'h005; imem[1] = 9'h1A3; imem[2] = HALT;
    @(negedge CLK);

    // Sequential fetch to halt
    add(1,0,0,0,0,0,0,0,0,0,  10'd0, 0,0, 16'd0);
    add(0,1,0,0,0,0,0,0,0,0,  10'd0, 1,0, 16'd0);
    add(0,0,0,0,0,0,0,0,0,0,  10'd1, 1,0, 16'd1);
    add(0,0,0,0,0,0,0,0,0,0,  10'd2, 1,0, 16'd2);
    add(0,0,0,0,0,0,0,0,0,0,  10'd2, 0,1, 16'd2);
    add(0,0,0,0,0,0,0,0,0,0,  10'd2, 0,1, 16'd2);
    run_vecs("seq");
    for (int a = 0; a < 3; a++) imem[a] = 9'(a);

    // Conditional branch taken / not taken, start ignored in RUN
    add(0,0,0,0,0,0,0,1,4'd3,10'h040, 10'd2, 0,1, 16'd2);
    add(0,0,0,0,0,0,0,1,4'd4,10'h005, 10'd2, 0,1, 16'd2);
    add(0,1,0,0,0,0,0,0,0,0,  10'd0, 1,0, 16'd0);
    for (int k = 1; k <= 6; k++) add(0,0,0,0,0,0,0,0,0,0, 10'(k), 1,0, 16'(k));
    add(0,0,0,1,0,4'd3,1,0,0,0, 10'h040, 1,0, 16'd7);
    add(0,0,0,0,0,0,0,0,0,0,    10'h041, 1,0, 16'd8);
    add(0,0,0,0,1,4'd4,0,0,0,0, 10'd5,   1,0, 16'd9);
    add(0,0,0,0,0,0,0,0,0,0,    10'd6,   1,0, 16'd10);
    add(0,0,0,1,0,4'd3,0,0,0,0, 10'd7,   1,0, 16'd11);
    add(0,1,0,0,0,0,0,0,0,0,    10'd8,   1,0, 16'd12);
    run_vecs("branch");

    // Compare result preserved across a two-cycle stall
    add(0,0,0,0,1,4'd4,0,0,0,0, 10'd5,   1,0, 16'd13);
    add(0,0,0,0,0,0,0,0,0,0,    10'd6,   1,0, 16'd14);
    add(0,0,1,1,0,4'd3,1,0,0,0, 10'd6,   1,0, 16'd14);
    add(0,0,1,1,0,4'd3,0,0,0,0, 10'd6,   1,0, 16'd14);
    add(0,0,0,1,0,4'd3,0,0,0,0, 10'h040, 1,0, 16'd15);
    run_vecs("stall");

    // LUT write/branch collision reads the old entry; both branch flags act as unconditional
    add(0,0,0,0,0,0,0,1,4'd2,10'h010,    10'h041, 1,0, 16'd16);
    add(0,0,0,0,1,4'd2,0,1,4'd2,10'h020, 10'h010, 1,0, 16'd17);
    add(0,0,0,0,0,0,0,0,0,0,             10'h011, 1,0, 16'd18);
    add(0,0,0,0,1,4'd2,0,0,0,0,          10'h020, 1,0, 16'd19);
    add(0,0,0,1,1,4'd2,0,0,0,0,          10'h020, 1,0, 16'd20);
    run_vecs("lut");

    // Reset mid-run, stalled halt, restart from DONE, LUT cleared by reset
    add(0,0,0,0,1,4'd4,0,0,0,0, 10'd5, 1,0, 16'd21);
    for (int k = 6; k <= 9; k++) add(0,0,0,0,0,0,0,0,0,0, 10'(k), 1,0, 16'(k + 16));
    add(1,0,0,0,0,0,0,0,0,0,            10'd0,   0,0, 16'd0);
    add(0,1,0,0,0,0,0,1,4'd5,10'h030,   10'd0,   1,0, 16'd0);
    add(0,0,0,0,1,4'd5,0,0,0,0,         10'h030, 1,0, 16'd1);
    add(0,0,1,0,0,0,0,0,0,0,            10'h030, 1,0, 16'd1);
    add(0,0,0,0,0,0,0,0,0,0,            10'h030, 0,1, 16'd1);
    add(0,1,0,0,0,0,0,0,0,0,            10'd0,   1,0, 16'd0);
    add(0,0,0,0,0,0,0,0,0,0,            10'd1,   1,0, 16'd1);
    add(0,0,0,0,1,4'd3,0,0,0,0,         10'd0,   1,0, 16'd2);
    run_vecs("rst");

    // Randomized run against the model
    for (int a = 0; a < 1024; a++)
      imem[a] = ($urandom_range(0, 23) == 0) ? HALT : 9'($urandom_range(0, 9'h1FE));
    reset = 1;
    @(posedge CLK);
    @(negedge CLK);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      check($sformatf("rnd[%0d] pc", c), 32'(pc), 32'(m_pc));
      check($sformatf("rnd[%0d] addr", c), 32'(imem_addr), 32'(m_pc));
      check($sformatf("rnd[%0d] running", c), 32'(running), 32'(m_run));
      check($sformatf("rnd[%0d] done", c), 32'(done), 32'(m_done));
      check($sformatf("rnd[%0d] count", c), 32'(instr_count), 32'(m_cnt));
      check($sformatf("rnd[%0d] instr", c), 32'(instruction), 32'(m_run ? imem[m_pc] : NOP));

      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 3) == 0);
      bc    = ($urandom_range(0, 3) == 0);
      bu    = ($urandom_range(0, 7) == 0);
      tsel  = 4'($urandom);
      tj    = 1'($urandom);
      we    = ($urandom_range(0, 3) == 0);
      waddr = 4'($urandom);
      wdata = 10'($urandom);

      if (reset) begin
        model_reset();
      end else begin
        hist_stall.push_back(stall);
        hist_tj.push_back(tj);
        cond  = model_cond();
        taken = bu || (bc && cond);
        if (!m_run) begin
          if (start) begin
            m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
          end
        end else if (!stall) begin
          if (imem[m_pc] == HALT) begin
            m_run = 0; m_done = 1;
          end else begin
            m_pc  = taken ? m_lut[tsel] : (m_pc + 1) % 1024;
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
          end
        end
        if (we) m_lut[waddr] = int'(wdata);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
    clear_inputs();

    // Narrow PC wrap and counter saturation
    @(posedge CLK);
    @(negedge CLK);
    reset2 = 0;
    check("wrap reset pc", 32'(pc2), 32'd0);
    check("wrap reset count", 32'(cnt2), 32'd0);
    check("wrap reset running", 32'(run2), 32'd0);
    start2 = 1;
    @(posedge CLK);
    @(negedge CLK);
    start2 = 0;
    check("wrap start running", 32'(run2), 32'd1);
    check("wrap start pc", 32'(pc2), 32'd0);
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      steps++;
      check($sformatf("wrap pc step %0d", steps), 32'(pc2), 32'(steps % 16));
      check($sformatf("wrap count step %0d", steps), 32'(cnt2), 32'(steps));
    end
    repeat (65534 - 20) @(posedge CLK);
    @(negedge CLK);
    steps = 65534;
    check("sat count FFFE", 32'(cnt2), 32'hFFFE);
    check("sat pc", 32'(pc2), 32'(steps % 16));
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      steps++;
      check($sformatf("sat count hold %0d", i), 32'(cnt2), 32'hFFFF);
      check($sformatf("sat pc %0d", i), 32'(pc2), 32'(steps % 16));
    end
    check("narrow done", 32'(done2), 32'd0);
    check("narrow instr", 32'(instr2), 32'(pc2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the ALU.
- Sequences the 9-bit instruction stream out of an asynchronous-read instruction memory and presents the current instruction to decode and to the ALU.
- Consumes the ALU's registered to_jump flag to resolve branches through a 16-entry jump-target LUT.
- Detects the halt instruction, signals done, and counts executed instructions.

Parameters:
- PC_W, 10, program counter / instruction address width
- START_PC, 0, PC loaded on start
- HALT_CODE, 9'h1FF, instruction encoding that halts execution
- NOP_CODE, 9'h100, instruction driven out when not running

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins execution from START_PC
- stall  in  1  hold PC and instruction this cycle
- imem_data  in  9  instruction memory read data, combinational from imem_addr
- imem_addr  out  PC_W  instruction memory address (equals pc)
- instruction  out  9  current instruction to decode/ALU
- pc  out  PC_W  current program counter
- branch_cond  in  1  decode: current instruction is a conditional branch
- branch_uncond  in  1  decode: current instruction is an unconditional branch
- target_sel  in  4  decode: jump-LUT index for the current branch
- to_jump  in  1  registered compare-equal flag from the ALU
- lut_we  in  1  jump-LUT write enable
- lut_waddr  in  4  jump-LUT write index
- lut_wdata  in  PC_W  jump-LUT write data
- running  out  1  state == RUN
- done  out  1  halt reached; held until the next start
- instr_count  out  16  instructions retired since start, saturating

Behaviour:
- Reset values: pc=START_PC, state=IDLE, running=0, done=0, instr_count=0, cond_hold=0. All LUT entries clear to 0. Reset mid-RUN aborts immediately with no completion.
- States:
  - IDLE: start -> RUN, with pc<=START_PC and instr_count<=0.
  - RUN: instruction==HALT_CODE and !stall -> DONE. A halt is not counted and does not advance the PC.
  - DONE: done=1 and pc frozen. start -> RUN (done<=0, pc<=START_PC, count cleared).
  - start while in RUN is ignored.
- imem_addr = pc at all times.
- instruction = imem_data in RUN; NOP_CODE in IDLE and DONE.
- Branch condition, because to_jump arrives one cycle after the CMP:
  - cond_eff = stall_q ? cond_hold : to_jump.
  - stall_q is stall registered; cond_hold is registered cond_eff.
  - This preserves the compare result across stalls.
- taken = branch_uncond | (branch_cond & cond_eff).
- Next PC, in RUN with !stall:
  - taken: pc <= lut[target_sel]
  - otherwise: pc <= pc+1, wrapping modulo 2^PC_W with no error
  - instr_count increments, saturating at 16'hFFFF
- stall=1: pc, instruction, and instr_count hold; stall takes priority over branch and halt evaluation.
- Jump LUT:
  - Registered write on the CLK edge when lut_we.
  - Combinational read of lut[target_sel].
  - A write and a branch to the same index in the same cycle uses the OLD entry.
  - Writes are accepted in every state.
- branch_cond and branch_uncond both set: treated as unconditional.
- Latency: the instruction at a branch target appears the cycle after the branch's non-stalled cycle. No delay slot.
- Single-cycle fetch: one instruction per non-stalled RUN cycle.

Test Plan:
- Sequential fetch and count: reset; start; imem returns the sequence 0x005, 0x1A3, 0x1FF at addresses 0..2.
  - pc goes 0,1,2 and then holds at 2.
  - done=1 on the cycle after the halt is presented.
  - instr_count=2; instruction = NOP_CODE in DONE.
- Conditional branch taken vs not: lut[3]=0x040; CMP at pc 5, conditional branch at pc 6 with target_sel=3.
  - to_jump=1: pc 6 -> 0x040.
  - to_jump=0: pc 6 -> 7.
- Stall across branch: to_jump=1 on the branch's first cycle, stall=1 for 2 cycles while to_jump drops to 0.
  - pc holds at 6 through the stall, then goes to 0x040.
  - instr_count unchanged during the stall.
- LUT write/read collision: lut[2]=0x010; in the same cycle write lut[2]=0x020 and take an unconditional branch with target_sel=2.
  - pc -> 0x010.
  - A later branch to index 2 -> 0x020.
- Wrap and saturation: PC_W=4, no halt in the program; pc 15 -> 0. Preload instr_count near 0xFFFF via a long run; it holds at 0xFFFF.
- Reset mid-run and restart:
  - Assert reset at pc=9: the next cycle shows pc=START_PC, IDLE, done=0, count=0.
  - start while in RUN: no effect on pc.
  - start in DONE: restarts at 0.
